// File: rtl/systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_array_ctrl
//
// Sequencer for an N x N grid of systolic_pe tiles. A job runs through these phases:
//   1. Load N*Depth weight rows into the PE shift chains.
//   2. Stream num_vectors data vectors per depth slot.
//   3. Drain the skewed pipeline with 2N-1 zero bubbles.
//   4. Pulse done.
// The controller also tags which bottom-row outputs carry real results.
//
// Parameters
//   N            array dimension (rows = cols = N)
//   Depth        weight slots per PE (must match systolic_pe Depth)
//   VecCntWidth  width of num_vectors
//
// Ports
//   clk            rising-edge clock
//   res            asynchronous active-high reset
//   start          begin a job (sampled in IDLE only)
//   num_vectors    vectors per depth slot, captured on accepted start
//   w_valid/w_ready  weight-row handshake (LOAD phase)
//   d_valid/d_ready  data-vector handshake (COMPUTE phase)
//   arr_en_l_b     shift one weight row into every PE
//   arr_valid      advance the array compute pipeline
//   arr_increment  last vector of the current depth slot (row-0 PEs)
//   arr_zero       input mux selects zero data (drain bubbles)
//   out_valid      bottom-row partial sums are a real result
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//   stall_cycles   (only with SYSTOLIC_CTRL_PERF_EN) handshake stall count
//
// Optional feature macro: SYSTOLIC_CTRL_PERF_EN adds the stall_cycles counter.
// -----------------------------------------------------------------------------
module systolic_array_ctrl #(
    parameter int N           = 4,
    parameter int Depth       = 1,
    parameter int VecCntWidth = 8
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   start,
    input  logic [VecCntWidth-1:0] num_vectors,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic                   d_valid,
    output logic                   d_ready,
    output logic                   arr_en_l_b,
    output logic                   arr_valid,
    output logic                   arr_increment,
    output logic                   arr_zero,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    // Pipeline latency through the skewed array, in arr_valid cycles.
    localparam int LAT  = 2 * N - 1;
    localparam int ROWS = N * Depth;
    localparam int WCW  = $clog2(N * Depth + 1);
    localparam int SCW  = $clog2(Depth + 1);
    localparam int DCW  = $clog2(2 * N);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_FIN
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [VecCntWidth-1:0] nv_q_reg;
    logic [WCW-1:0]         w_cnt_reg;
    logic [VecCntWidth-1:0] vec_cnt_reg;
    logic [SCW-1:0]         slot_cnt_reg;
    logic [DCW-1:0]         drain_cnt_reg;

    // Output flags registered from the next-state decode, so they are
    // glitch-free functions of the current state.
    logic w_ready_reg;
    logic d_ready_reg;
    logic arr_zero_reg;
    logic busy_reg;
    logic done_reg;

    logic start_accept;
    logic w_accept;
    logic d_accept;
    logic last_row;
    logic last_vec;
    logic last_slot;
    logic last_drain;

    logic [LAT-1:0] tag_reg;
    logic           tag_in;

    // -------------------------------------------------------------------------
    // Handshake decode and terminal-count detection
    // -------------------------------------------------------------------------
    always_comb begin
        start_accept = (state_reg == ST_IDLE) && start;
        // w_ready_reg / d_ready_reg are only high in LOAD / COMPUTE.
        w_accept     = w_ready_reg && w_valid;
        d_accept     = d_ready_reg && d_valid;
        last_row     = (w_cnt_reg == WCW'(ROWS - 1));
        // Only evaluated in COMPUTE, where nv_q_reg is known to be non-zero.
        last_vec     = (vec_cnt_reg == (nv_q_reg - VecCntWidth'(1)));
        last_slot    = (slot_cnt_reg == SCW'(Depth - 1));
        last_drain   = (drain_cnt_reg == DCW'(LAT - 1));
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept && last_row) begin
                    // An empty job skips the data phase entirely.
                    state_next = (nv_q_reg == '0) ? ST_DRAIN : ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (d_accept && last_vec && last_slot) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_drain) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state, registered output flags and phase counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_reg     <= ST_IDLE;
            nv_q_reg      <= '0;
            w_cnt_reg     <= '0;
            vec_cnt_reg   <= '0;
            slot_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            w_ready_reg   <= 1'b0;
            d_ready_reg   <= 1'b0;
            arr_zero_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            w_ready_reg  <= (state_next == ST_LOAD);
            d_ready_reg  <= (state_next == ST_COMPUTE);
            arr_zero_reg <= (state_next == ST_DRAIN);
            busy_reg     <= (state_next != ST_IDLE);
            done_reg     <= (state_next == ST_FIN);

            if (start_accept) begin
                nv_q_reg <= num_vectors;
            end

            // Weight rows: wraps to 0 on the terminal row so the next job
            // starts clean.
            if (w_accept) begin
                w_cnt_reg <= last_row ? '0 : (w_cnt_reg + WCW'(1));
            end

            // Vectors count within a slot; the slot advances on each slot's
            // last vector and both return to 0 after the final slot.
            if (d_accept) begin
                if (last_vec) begin
                    vec_cnt_reg  <= '0;
                    slot_cnt_reg <= last_slot ? '0 : (slot_cnt_reg + SCW'(1));
                end else begin
                    vec_cnt_reg <= vec_cnt_reg + VecCntWidth'(1);
                end
            end

            if (state_reg == ST_DRAIN) begin
                drain_cnt_reg <= last_drain ? '0 : (drain_cnt_reg + DCW'(1));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result tagging: one tag bit follows each pipeline slot through the
    // array. A tag only moves when the array itself advances, so a frozen
    // array (d_valid low) also freezes the tags.
    // -------------------------------------------------------------------------
    assign tag_in = d_accept;

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge res) begin
                    if (res) begin
                        tag_reg[gi] <= 1'b0;
                    end else if (arr_valid) begin
                        tag_reg[gi] <= tag_in;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or posedge res) begin
                    if (res) begin
                        tag_reg[gi] <= 1'b0;
                    end else if (arr_valid) begin
                        tag_reg[gi] <= tag_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign w_ready       = w_ready_reg;
    assign d_ready       = d_ready_reg;
    // en_l_b follows w_valid in the same cycle so the buffer needs no extra
    // pipeline stage.
    assign arr_en_l_b    = w_accept;
    assign arr_valid     = d_accept || arr_zero_reg;
    assign arr_increment = d_accept && last_vec;
    assign arr_zero      = arr_zero_reg;
    assign out_valid     = tag_reg[LAT-1] && arr_valid;
    assign busy          = busy_reg;
    assign done          = done_reg;

`ifdef SYSTOLIC_CTRL_PERF_EN
    // -------------------------------------------------------------------------
    // Stall counter: cycles where the controller was ready but the buffer was
    // not. Cleared on each accepted start and saturating.
    // -------------------------------------------------------------------------
    logic [31:0] stall_cnt_reg;
    logic        stall_hit;

    assign stall_hit = (w_ready_reg && !w_valid) || (d_ready_reg && !d_valid);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            stall_cnt_reg <= '0;
        end else if (start_accept) begin
            stall_cnt_reg <= '0;
        end else if (stall_hit && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_reg;
`endif

endmodule
